io_axil_uart_regs: RTL

- AXI4-Lite responder for the core's S_AXI_* I/O master port, used by the in/out instructions.
- Register map: RX byte FIFO, TX byte FIFO, status and control.
- Serial side is byte streams to/from the UART serializer/deserializer.
- Sits between core_top's I/O port and the UART PHY in the board top.

---
 rtl/io_axil_pkg.sv | 36 +++
 rtl/io_sync_fifo.sv | 51 +++++
 rtl/io_axil_uart_regs.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/io_axil_pkg.sv
// Shared register map, STAT/CTRL bit positions and AXI response codes for io_axil_uart_regs.
// The optional interrupt logic is built only when IO_AXIL_IRQ_EN is defined.
package io_axil_pkg;

  localparam logic [3:0] REG_RX   = 4'h0;
  localparam logic [3:0] REG_TX   = 4'h4;
  localparam logic [3:0] REG_STAT = 4'h8;
  localparam logic [3:0] REG_CTRL = 4'hC;

  localparam int unsigned STAT_RX_NEMPTY = 0;
  localparam int unsigned STAT_RX_FULL   = 1;
  localparam int unsigned STAT_TX_EMPTY  = 2;
  localparam int unsigned STAT_TX_FULL   = 3;
  localparam int unsigned STAT_IRQ_EN    = 4;
  localparam int unsigned STAT_OVERRUN   = 5;

  localparam int unsigned CTRL_TX_FLUSH = 0;
  localparam int unsigned CTRL_RX_FLUSH = 1;
  localparam int unsigned CTRL_IRQ_EN   = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {SelRx, SelTx, SelStat, SelCtrl} reg_sel_e;

  // Only address bits [3:2] select a register; the low bits are ignored.
  function automatic reg_sel_e reg_sel(input logic [3:0] addr);
    case ({addr[3:2], 2'b00})
      REG_RX:   return SelRx;
      REG_TX:   return SelTx;
      REG_STAT: return SelStat;
      default:  return SelCtrl;
    endcase
  endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush, occupancy count and full/empty flags.
// Flush overrides any same-cycle push or pop.
module io_sync_fifo #(
  parameter int unsigned Width     = 8,
  parameter int unsigned AddrWidth = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push,
  input  logic [Width-1:0]     wdata,
  input  logic                 pop,
  output logic [Width-1:0]     rdata,
  output logic [AddrWidth:0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned Depth = 1 << AddrWidth;

  logic [Width-1:0]     mem [Depth];
  logic [AddrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrWidth:0]   count_q;
  logic                 do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AddrWidth + 1)'(Depth));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is legal only when a pop frees the slot in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AddrWidth + 1)'(do_push) - (AddrWidth + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/io_axil_uart_regs.sv
// AXI4-Lite register block bridging the core I/O port to UART byte streams (RX/TX FIFOs,
// STAT, CTRL). Define IO_AXIL_IRQ_EN to build the interrupt pulse logic; otherwise IRQ is 0.
module io_axil_uart_regs
  import io_axil_pkg::*;
#(
  parameter int unsigned FIFO_AW = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  S_AXI_AWADDR,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [3:0]  S_AXI_ARADDR,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  output logic [7:0]  TX_TDATA,
  output logic        TX_TVALID,
  input  logic        TX_TREADY,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic        IRQ
);

  logic        aw_held_q, w_held_q, wstb0_q, bvalid_q, rvalid_q, overrun_q;
  logic [3:0]  aw_addr_q;
  logic [7:0]  wdata_q;
  logic [1:0]  bresp_q;
  logic [31:0] rdata_q, rd_data, stat;
  logic        aw_hs, w_hs, ar_hs, wr_exec, tx_wr, tx_err, ctrl_wr;
  logic        tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic        rx_pop, rx_flush, rx_full, rx_empty, stat_rd, irq_en;
  logic [7:0]  tx_head, rx_head;
  logic [FIFO_AW:0] tx_count, rx_count;
  reg_sel_e    wr_sel, rd_sel;

  assign S_AXI_AWREADY = ~aw_held_q & ~bvalid_q;
  assign S_AXI_WREADY  = ~w_held_q & ~bvalid_q;
  assign S_AXI_ARREADY = ~rvalid_q;
  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  assign wr_exec  = aw_held_q & w_held_q;
  assign wr_sel   = reg_sel(aw_addr_q);
  assign tx_wr    = wr_exec & (wr_sel == SelTx) & wstb0_q;
  assign tx_push  = tx_wr & ~tx_full;
  assign tx_err   = tx_wr & tx_full;
  assign ctrl_wr  = wr_exec & (wr_sel == SelCtrl) & wstb0_q;
  assign tx_flush = ctrl_wr & wdata_q[CTRL_TX_FLUSH];
  assign rx_flush = ctrl_wr & wdata_q[CTRL_RX_FLUSH];

  assign rd_sel  = reg_sel(S_AXI_ARADDR);
  assign rx_pop  = ar_hs & (rd_sel == SelRx);
  assign stat_rd = ar_hs & (rd_sel == SelStat);

  assign TX_TVALID = ~tx_empty;
  assign TX_TDATA  = tx_head;
  assign tx_pop    = TX_TVALID & TX_TREADY;

  io_sync_fifo #(.Width(8), .AddrWidth(FIFO_AW)) u_tx_fifo (
    .clk(CLK), .rst(RST), .flush(tx_flush), .push(tx_push), .wdata(wdata_q), .pop(tx_pop),
    .rdata(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );

  io_sync_fifo #(.Width(8), .AddrWidth(FIFO_AW)) u_rx_fifo (
    .clk(CLK), .rst(RST), .flush(rx_flush), .push(RX_VALID), .wdata(RX_DATA), .pop(rx_pop),
    .rdata(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );

  always_comb begin
    stat                 = '0;
    stat[STAT_RX_NEMPTY] = ~rx_empty;
    stat[STAT_RX_FULL]   = rx_full;
    stat[STAT_TX_EMPTY]  = tx_empty;
    stat[STAT_TX_FULL]   = tx_full;
    stat[STAT_IRQ_EN]    = irq_en;
    stat[STAT_OVERRUN]   = overrun_q;
  end

  always_comb begin
    rd_data = '0;
    unique case (rd_sel)
      SelRx:   if (!rx_empty) rd_data = {24'b0, rx_head};
      SelStat: rd_data = stat;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstb0_q   <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= S_AXI_WDATA[7:0];
        wstb0_q  <= S_AXI_WSTB[0];
      end
      if (wr_exec) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= tx_err ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
      // A new overrun beats a same-cycle STAT read clearing the flag.
      if (RX_VALID && rx_full && !rx_pop) overrun_q <= 1'b1;
      else if (stat_rd)                   overrun_q <= 1'b0;
    end
  end

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = RESP_OKAY;

`ifdef IO_AXIL_IRQ_EN
  logic irq_en_q, rx_empty_q, tx_empty_q, irq_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      irq_en_q   <= 1'b0;
      rx_empty_q <= 1'b1;
      tx_empty_q <= 1'b1;
      irq_q      <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= wdata_q[CTRL_IRQ_EN];
      rx_empty_q <= rx_empty;
      tx_empty_q <= tx_empty;
      irq_q      <= irq_en_q & ((rx_empty_q & ~rx_empty) | (~tx_empty_q & tx_empty));
    end
  end

  assign irq_en = irq_en_q;
  assign IRQ    = irq_q;
`else
  assign irq_en = 1'b0;
  assign IRQ    = 1'b0;
`endif

endmodule
